// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB slave UART transmitter. Bytes written to DATA queue in a
// small FIFO and are sent on txd as 8N1 frames, LSB first. STATUS reports
// FIFO full/empty/count and whether the shifter is active.
// Ports:
//   clk, reset            - clock; synchronous active-low reset
//   paddr, pwrite, psel,
//   penable, pwdata       - APB requester inputs
//   prdata, pready,
//   pslverr               - APB completer outputs (registered, zero wait states)
//   txd                   - UART serial output, idle high (registered)
//   tx_busy               - frame in flight or FIFO non-empty (registered)
module apb_uart_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        txd,
    output logic        tx_busy
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                wr_ok_q, wr_ok_d;
    logic                txd_q, txd_d;
    logic                tx_busy_q, tx_busy_d;

    logic                setup, hit, full, empty, active, acc_err, push, pop;
    logic [1:0]          offset;
    logic [31:0]         status_word, rdata;

    // Address low bits and upper write-data byte lanes carry no meaning here.
    logic unused_apb;
    assign unused_apb = ^{paddr[1:0], pwdata[31:8]};

    // Decode of the access presented in the setup cycle.
    always_comb begin
        setup       = psel & ~penable;
        hit         = (paddr[31:4] == BASE_ADDR[31:4]);
        offset      = paddr[3:2];
        full        = (count_q == CNT_FULL);
        empty       = (count_q == '0);
        active      = (state_q != S_IDLE);
        acc_err     = ~hit | offset[1]
                    | (pwrite & (offset == 2'd1))
                    | (pwrite & (offset == 2'd0) & full);
        status_word = {20'd0, 4'(count_q), 5'd0, active, empty, full};
        rdata       = (~acc_err & ~pwrite & (offset == 2'd1)) ? status_word : 32'd0;
    end

    // APB response: everything is decided at the setup edge; the push
    // happens at completion using the full check captured then.
    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        wr_ok_d   = wr_ok_q;
        if (setup) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = rdata;
            wr_ok_d   = ~acc_err & pwrite & (offset == 2'd0);
        end
        push = psel & penable & pready_q & wr_ok_q;
    end

    // TX FSM; txd is driven from the registered state, one cycle behind it.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    // Back-to-back frames: next byte goes straight to START.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
        tx_busy_d = active | ~empty;
    end

    // FIFO pointers, count and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = pwdata[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_ok_q   <= 1'b0;
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wr_ok_q   <= wr_ok_d;
            txd_q     <= txd_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign txd     = txd_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_apb_uart_tx.sv
// Testbench for apb_uart_tx (CLK_DIV=4, FIFO_DEPTH=4). The reference model
// keeps a list of accepted bytes with their completion cycle and computed
// frame start; expected txd, tx_busy and STATUS follow from those times.
module tb_apb_uart_tx;
    localparam int CLKD  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CLKD;
    localparam int MAXF  = 32;
    localparam int NEVER = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        txd;
    logic        tx_busy;

    apb_uart_tx #(
        .CLK_DIV    (CLKD),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (32'h8000_0010)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_s = 1'b0;
    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_s = reset;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Model: accepted bytes, completion cycle, frame start, reset-kill edge.
    int         fr_e    [MAXF];
    int         fr_s    [MAXF];
    int         fr_kill [MAXF];
    logic [7:0] fr_b    [MAXF];
    int         nfr       = 0;
    int         line_free = 0;

    function automatic logic exp_txd(input int t);
        logic [7:0] b;
        int k;
        exp_txd = 1'b1;
        for (int i = 0; i < nfr; i++) begin
            if (fr_kill[i] > t && t >= fr_s[i] && t < fr_s[i] + FRAME) begin
                k = (t - fr_s[i]) / CLKD;
                b = fr_b[i];
                if (k == 0)      exp_txd = 1'b0;
                else if (k <= 8) exp_txd = b[3'(k - 1)];
            end
        end
    endfunction

    function automatic logic exp_busy(input int t);
        exp_busy = 1'b0;
        for (int i = 0; i < nfr; i++)
            if (fr_kill[i] > t && t >= fr_e[i] + 1 && t <= fr_s[i] + FRAME - 1)
                exp_busy = 1'b1;
    endfunction

    // Bytes still waiting in the FIFO as seen by a setup edge S.
    function automatic int fifo_cnt(input int s_edge);
        fifo_cnt = 0;
        for (int i = 0; i < nfr; i++)
            if (fr_kill[i] > s_edge - 1 && fr_s[i] > s_edge)
                fifo_cnt = fifo_cnt + 1;
    endfunction

    function automatic logic shifting(input int s_edge);
        shifting = 1'b0;
        for (int i = 0; i < nfr; i++)
            if (fr_kill[i] > s_edge - 1 && fr_s[i] <= s_edge && s_edge <= fr_s[i] + FRAME - 1)
                shifting = 1'b1;
    endfunction

    function automatic logic [31:0] status_at(input int s_edge);
        int c;
        c = fifo_cnt(s_edge);
        status_at = {20'd0, 4'(c), 5'd0, shifting(s_edge), (c == 0), (c == DEPTH)};
    endfunction

    // Per-cycle comparison of the serial side against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (!rst_s) begin
                chk("txd_in_reset", 32'(txd), 32'd1);
                chk("busy_in_reset", 32'(tx_busy), 32'd0);
            end else begin
                chk("txd", 32'(txd), 32'(exp_txd(cyc)));
                chk("tx_busy", 32'(tx_busy), 32'(exp_busy(cyc)));
            end
        end
    end

    task automatic wait_to(input int t);
        if (cyc > t) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, t);
        end
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer (setup + access), checked against the model.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output logic err, output logic [31:0] rd);
        int          s_edge, cnt, c_edge;
        logic [1:0]  off;
        logic        e;
        logic [31:0] rexp;
        s_edge = cyc + 1;
        off    = addr[3:2];
        cnt    = fifo_cnt(s_edge);
        e      = (addr[31:4] != 28'h8000001) || off[1] || (wr && off == 2'd1)
              || (wr && off == 2'd0 && cnt == DEPTH);
        rexp   = (!e && !wr && off == 2'd1) ? status_at(s_edge) : 32'd0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk);
        #1;
        chk("pready_access", 32'(pready), 32'd1);
        chk("pslverr", 32'(pslverr), 32'(e));
        chk("prdata", prdata, rexp);
        err = pslverr;
        rd  = prdata;
        penable = 1'b1;
        @(posedge clk);
        #1;
        c_edge = cyc;
        if (wr && !e && nfr < MAXF) begin
            fr_e[nfr]    = c_edge;
            fr_s[nfr]    = (c_edge + 2 > line_free) ? c_edge + 2 : line_free;
            fr_b[nfr]    = data[7:0];
            fr_kill[nfr] = NEVER;
            line_free    = fr_s[nfr] + FRAME;
            nfr          = nfr + 1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("pready_idle", 32'(pready), 32'd0);
    endtask

    localparam logic [31:0] A_DATA = 32'h8000_0010;
    localparam logic [31:0] A_STAT = 32'h8000_0014;

    initial begin
        logic        err;
        logic [31:0] rd;
        int          c, s1;

        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        err;
        logic [31:0] rd;
        int          c, s1;

        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        chk("t1_prdata_rst", prdata, 32'd0);
        chk("t1_pready_rst", 32'(pready), 32'd0);
        chk("t1_pslverr_rst", 32'(pslverr), 32'd0);
        chk("t1_txd_rst", 32'(txd), 32'd1);
        chk("t1_busy_rst", 32'(tx_busy), 32'd0);
        reset = 1'b1;
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t1_status", rd, 32'h0000_0002);
        chk("t1_err", 32'(err), 32'd0);

        // 2. single byte 0x55, upper lanes carry junk
        apb(1'b1, A_DATA, 32'hABCD_EF55, err, rd);
        c = cyc;
        chk("t2_err", 32'(err), 32'd0);
        wait_to(c + 1);
        chk("t2_txd_pre", 32'(txd), 32'd1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CLKD; j++) begin
                wait_to(c + 2 + CLKD * k + j);
                chk("t2_bit", 32'(txd), 32'(k % 2));
                chk("t2_busy", 32'(tx_busy), 32'd1);
            end
        end
        wait_to(c + 42);
        chk("t2_busy_end", 32'(tx_busy), 32'd0);
        chk("t2_txd_end", 32'(txd), 32'd1);

        // 4. decode errors
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t4_status_pre", rd, 32'h0000_0002);
        apb(1'b0, 32'h8000_0018, 32'd0, err, rd);
        chk("t4_rd18_err", 32'(err), 32'd1);
        chk("t4_rd18_data", rd, 32'd0);
        apb(1'b1, A_STAT, 32'h0000_00FF, err, rd);
        chk("t4_wr_status_err", 32'(err), 32'd1);
        apb(1'b1, 32'h8000_0020, 32'h0000_0033, err, rd);
        chk("t4_nohit_err", 32'(err), 32'd1);
        apb(1'b0, A_DATA, 32'd0, err, rd);
        chk("t4_rd_data_err", 32'(err), 32'd0);
        chk("t4_rd_data_val", rd, 32'd0);
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t4_status_post", rd, 32'h0000_0002);
        chk("t4_txd", 32'(txd), 32'd1);

        // 3. FIFO full, back-to-back frames
        s1 = 0;
        for (int i = 0; i < 5; i++) begin
            apb(1'b1, A_DATA, 32'(i + 1), err, rd);
            if (i == 0) s1 = cyc + 2;
            chk("t3_wr_err", 32'(err), 32'd0);
        end
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t3_status_full", rd, 32'h0000_0405);
        apb(1'b1, A_DATA, 32'h0000_0006, err, rd);
        chk("t3_wr6_err", 32'(err), 32'd1);
        for (int f = 1; f < 5; f++) begin
            wait_to(s1 + FRAME * f - 1);
            chk("t3_stop", 32'(txd), 32'd1);
            wait_to(s1 + FRAME * f);
            chk("t3_start", 32'(txd), 32'd0);
            chk("t3_busy", 32'(tx_busy), 32'd1);
        end
        wait_to(s1 + 199);
        chk("t3_busy_last", 32'(tx_busy), 32'd1);
        wait_to(s1 + 200);
        chk("t3_busy_done", 32'(tx_busy), 32'd0);
        chk("t3_txd_done", 32'(txd), 32'd1);

        // 6. status during transmit
        apb(1'b1, A_DATA, 32'h0000_0010, err, rd);
        c = cyc;
        wait_to(c + 2);
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t6_status_tx", rd, 32'h0000_0006);
        wait_to(c + 2 + FRAME + 1);
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t6_status_idle", rd, 32'h0000_0002);

        // 5. reset in the middle of data bit 3 of 0xA5
        apb(1'b1, A_DATA, 32'h0000_00A5, err, rd);
        c = cyc;
        wait_to(c + 2 + 4 * CLKD + 1);
        chk("t5_bit3", 32'(txd), 32'd0);
        for (int i = 0; i < nfr; i++)
            if (fr_kill[i] > cyc + 1) fr_kill[i] = cyc + 1;
        line_free = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_txd_rst", 32'(txd), 32'd1);
        chk("t5_busy_rst", 32'(tx_busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apb(1'b0, A_STAT, 32'd0, err, rd);
        chk("t5_status", rd, 32'h0000_0002);
        wait_to(cyc + 60);
        chk("t5_txd_quiet", 32'(txd), 32'd1);
        chk("t5_busy_quiet", 32'(tx_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
